tl_phase_sequencer: RTL and testbench
=====================================

Name: tl_phase_sequencer

Overview:
- Moore FSM controller for a two-road intersection (road A, road B) in the Traffic Light Controller project.
- Holds its 2-bit phase in a register with async reset and advances it from the road sensors and an internal dwell timer.
- Drives the light-code outputs that the display/decoder stage consumes.

Parameters:
TW, 4, dwell timer width in bits
MIN_GREEN, 4, minimum cycles a green phase lasts before it may end (1 <= MIN_GREEN <= MAX_GREEN)
MAX_GREEN, 12, cycles after which a green phase yields to a waiting cross road even if its own traffic persists (MAX_GREEN <= 2**TW)
YELLOW_CYCLES, 2, exact cycles spent in each yellow phase (1 <= YELLOW_CYCLES <= 2**TW)

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset_n  input  1  asynchronous, active-low reset
ta  input  1  traffic present on road A (synchronous to clk)
tb  input  1  traffic present on road B (synchronous to clk)
la  output  2  road A light: 00 green, 01 yellow, 10 red
lb  output  2  road B light: same encoding as la
phase  output  2  registered phase: 00 A_GREEN, 01 A_YELLOW, 11 B_GREEN, 10 B_YELLOW
timer  output  TW  cycles elapsed in the current phase

Behaviour:
- Interface: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values, applied immediately when reset_n falls with no clock edge needed:
  - phase = 00 (A_GREEN), timer = 0, la = 00, lb = 10.
- Registers: phase and timer only. la and lb are pure decodes of phase (Moore), so they change only with phase.
- Light decode:
  - A_GREEN: la = 00, lb = 10
  - A_YELLOW: la = 01, lb = 10
  - B_GREEN: la = 10, lb = 00
  - B_YELLOW: la = 10, lb = 01
- Red never overlaps: one road is always 10.
- Timer rules:
  - Resets to 0 on the edge that changes phase; otherwise increments by 1 each edge.
  - In green phases it saturates at MAX_GREEN-1 and never wraps.
- A_GREEN -> A_YELLOW at an edge when tb=1 and either:
  - timer >= MIN_GREEN-1 and ta=0, or
  - timer >= MAX_GREEN-1 (regardless of ta).
- Otherwise A_GREEN holds. With tb=0, A_GREEN holds forever.
- B_GREEN -> B_YELLOW: mirror image, with ta and tb swapped.
- A_YELLOW -> B_GREEN and B_YELLOW -> A_GREEN at the edge where timer == YELLOW_CYCLES-1.
  - Sensors are ignored in yellow phases; yellow lasts exactly YELLOW_CYCLES cycles.
- Minimum green duration is MIN_GREEN cycles; maximum green under cross-demand is MAX_GREEN cycles.
- Sensors are sampled every edge with no latching. A cross-road request that drops before the switch condition holds causes no switch.
- Simultaneous ta=1 and tb=1: the current green runs to MAX_GREEN, then alternates. Neither road starves.
- Reset mid-phase, including yellow: returns to A_GREEN with timer 0 asynchronously. Normal operation resumes at the first edge after reset_n rises.
- Unused encodings are unreachable. Next-state logic maps any other value to A_GREEN.

Test Plan:
- Reset held 3 cycles, then released with ta=1, tb=0 for 20 cycles -> phase stays 00, la=00, lb=10; timer counts 0..11 and holds at 11.
- Release with ta=0, tb=1 -> phase 00 for cycles 0-3, 01 for cycles 4-5, 11 from cycle 6 (la=10, lb=00); timer returns to 0 on each change.
- ta=1, tb=1 constant -> A_GREEN 12 cycles, A_YELLOW 2, B_GREEN 12, B_YELLOW 2, then repeats; period 28 cycles.
- ta=1, tb pulsed high only at timer=1..2 -> no phase change; phase stays 00 for 20+ cycles.
- reset_n driven low mid-A_YELLOW, between clock edges -> phase=00, timer=0, la=00, lb=10 before the next rising edge; on release with ta=0, tb=1 the 4+2 cycle sequence restarts.
- Change ta/tb during yellow phases -> yellow lasts exactly 2 cycles; la and lb never both 00, and never green on one road with yellow on the other.

Source files
------------

// File: rtl/tl_phase_sequencer.sv
// Two-road traffic light phase sequencer: a Moore FSM with a dwell timer.
// It drives the per-road light codes from the registered phase.
module tl_phase_sequencer #(
    parameter int TW            = 4,
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 12,
    parameter int YELLOW_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ta,
    input  logic          tb,
    output logic [1:0]    la,
    output logic [1:0]    lb,
    output logic [1:0]    phase,
    output logic [TW-1:0] timer
);

    typedef enum logic [1:0] {
        A_GREEN  = 2'b00,
        A_YELLOW = 2'b01,
        B_GREEN  = 2'b11,
        B_YELLOW = 2'b10
    } phase_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // Timer values on which a transition may be taken (last cycle of a window).
    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_CYCLES - 1);

    phase_t        state_q;
    phase_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          in_green;
    logic          min_done;
    logic          max_done;
    logic          yel_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= A_GREEN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        min_done = (timer_q >= MIN_LAST);
        max_done = (timer_q >= MAX_LAST);
        yel_done = (timer_q == YEL_LAST);
        in_green = (state_q == A_GREEN) || (state_q == B_GREEN);
        state_d  = state_q;

        // A green yields only to cross demand: early if its own road is idle,
        // unconditionally once the maximum dwell is reached.
        case (state_q)
            A_GREEN: begin
                if (tb && ((min_done && !ta) || max_done))
                    state_d = A_YELLOW;
            end
            A_YELLOW: begin
                if (yel_done)
                    state_d = B_GREEN;
            end
            B_GREEN: begin
                if (ta && ((min_done && !tb) || max_done))
                    state_d = B_YELLOW;
            end
            B_YELLOW: begin
                if (yel_done)
                    state_d = A_GREEN;
            end
            default: state_d = A_GREEN;
        endcase

        // Green dwell saturates so a long uncontested green never wraps.
        if (state_d != state_q)
            timer_d = '0;
        else if (in_green && max_done)
            timer_d = timer_q;
        else
            timer_d = timer_q + TW'(1);
    end

    always_comb begin
        la = LIGHT_RED;
        lb = LIGHT_RED;
        case (state_q)
            A_GREEN:  la = LIGHT_GREEN;
            A_YELLOW: la = LIGHT_YELLOW;
            B_GREEN:  lb = LIGHT_GREEN;
            B_YELLOW: lb = LIGHT_YELLOW;
            default: begin
                la = LIGHT_RED;
                lb = LIGHT_RED;
            end
        endcase
    end

    assign phase = state_q;
    assign timer = timer_q;

endmodule

// File: tb/tb_tl_phase_sequencer.sv
// Directed scoreboard bench for tl_phase_sequencer with default parameters
// (MIN_GREEN=4, MAX_GREEN=12, YELLOW_CYCLES=2).
module tb_tl_phase_sequencer;

    localparam int TW = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b1;
    logic          ta      = 1'b0;
    logic          tb      = 1'b0;
    logic [1:0]    la;
    logic [1:0]    lb;
    logic [1:0]    phase;
    logic [TW-1:0] timer;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string         tag;
        logic [1:0]    ph;
        logic [TW-1:0] tm;
    } exp_t;

    exp_t sb[$];

    tl_phase_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ta      (ta),
        .tb      (tb),
        .la      (la),
        .lb      (lb),
        .phase   (phase),
        .timer   (timer)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] la_of(input logic [1:0] ph);
        case (ph)
            2'b00:   return 2'b00;
            2'b01:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [1:0] lb_of(input logic [1:0] ph);
        case (ph)
            2'b11:   return 2'b00;
            2'b10:   return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1:0] ph, input logic [TW-1:0] tm);
        chk({tag, ".phase"}, {2'b00, phase}, {2'b00, ph});
        chk({tag, ".timer"}, timer, tm);
        chk({tag, ".la"}, {2'b00, la}, {2'b00, la_of(ph)});
        chk({tag, ".lb"}, {2'b00, lb}, {2'b00, lb_of(ph)});
    endtask

    // Drive sensors for one edge, queue the expected post-edge state, compare.
    task automatic cyc(input string tag, input logic a, input logic b,
                       input logic [1:0] ph, input int tm);
        exp_t e;
        exp_t got;
        ta    = a;
        tb    = b;
        e.tag = tag;
        e.ph  = ph;
        e.tm  = TW'(tm);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check_state(got.tag, got.ph, got.tm);
    endtask

    // Entered just after a rising edge: reset asserts between edges.
    task automatic do_reset(input string tag);
        #2;
        reset_n = 1'b0;
        ta      = 1'b0;
        tb      = 1'b0;
        #1;
        check_state({tag, ".async"}, 2'b00, '0);
        @(posedge clk);
        #1;
        check_state({tag, ".held"}, 2'b00, '0);
        reset_n = 1'b1;
    endtask

    initial begin
        int p;
        #1 reset_n = 1'b0;
        #1 check_state("rst0.async", 2'b00, '0);
        repeat (3) @(posedge clk);
        #1 check_state("rst0.held", 2'b00, '0);
        reset_n = 1'b1;

        // A traffic only: A green holds, timer saturates at 11.
        for (int k = 1; k <= 20; k++)
            cyc($sformatf("s1.c%0d", k), 1'b1, 1'b0, 2'b00, (k < 11) ? k : 11);

        // B demand only: 4 cycles green, then into yellow; reset there.
        do_reset("r2");
        for (int k = 1; k <= 4; k++)
            cyc($sformatf("s2a.c%0d", k), 1'b0, 1'b1, (k < 4) ? 2'b00 : 2'b01, (k < 4) ? k : 0);
        do_reset("ryel");
        for (int k = 1; k <= 10; k++) begin
            if (k < 4)       cyc($sformatf("s2.c%0d", k), 1'b0, 1'b1, 2'b00, k);
            else if (k < 6)  cyc($sformatf("s2.c%0d", k), 1'b0, 1'b1, 2'b01, k - 4);
            else             cyc($sformatf("s2.c%0d", k), 1'b0, 1'b1, 2'b11, k - 6);
        end

        // Both roads busy: 12/2/12/2 rotation with period 28.
        do_reset("r3");
        for (int n = 1; n <= 60; n++) begin
            p = n % 28;
            if (p < 12)      cyc($sformatf("s3.c%0d", n), 1'b1, 1'b1, 2'b00, p);
            else if (p < 14) cyc($sformatf("s3.c%0d", n), 1'b1, 1'b1, 2'b01, p - 12);
            else if (p < 26) cyc($sformatf("s3.c%0d", n), 1'b1, 1'b1, 2'b11, p - 14);
            else             cyc($sformatf("s3.c%0d", n), 1'b1, 1'b1, 2'b10, p - 26);
        end

        // Short B pulse at timer 1..2 is dropped; later a one-cycle B request
        // at max dwell switches; sensors toggle during yellows.
        do_reset("r4");
        for (int k = 1; k <= 20; k++)
            cyc($sformatf("s4.c%0d", k), 1'b1, (k == 2 || k == 3), 2'b00, (k < 11) ? k : 11);
        cyc("s4.c21", 1'b1, 1'b1, 2'b01, 0);
        cyc("s4.c22", 1'b0, 1'b1, 2'b01, 1);
        cyc("s4.c23", 1'b1, 1'b0, 2'b11, 0);
        cyc("s4.c24", 1'b1, 1'b0, 2'b11, 1);
        cyc("s4.c25", 1'b1, 1'b0, 2'b11, 2);
        cyc("s4.c26", 1'b1, 1'b0, 2'b11, 3);
        cyc("s4.c27", 1'b1, 1'b0, 2'b10, 0);
        cyc("s4.c28", 1'b0, 1'b1, 2'b10, 1);
        cyc("s4.c29", 1'b0, 1'b1, 2'b00, 0);
        cyc("s4.c30", 1'b0, 1'b0, 2'b00, 1);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
